// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access size encodings,
// arbitration state type and byte-enable width.
package dm_arbiter_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int BE_W = 4;

   typedef enum logic {
      CPU_PRI,
      DMA_FORCE
   } arb_state_t;

endpackage

// File: rtl/dm_lane_align.sv
// CPU lane handling for the data memory: byte enables, store replication,
// load extraction with sign/zero extension, and misalign/range exception detect.
module dm_lane_align
   import dm_arbiter_pkg::*;
#(
   parameter int DM_WORDS = 4096
) (
   input  logic [1:0]      size,
   input  logic            sign,
   input  logic [31:0]     addr,
   input  logic [31:0]     wdata,
   input  logic [31:0]     mem_rdata,
   output logic [BE_W-1:0] be,
   output logic [31:0]     wdata_rep,
   output logic [31:0]     rdata,
   output logic            exc
);

   // One past the last valid byte address, held in 33 bits so large depths cannot wrap.
   localparam logic [32:0] LIMIT = 33'(DM_WORDS) << 2;

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign lane_b = mem_rdata[{addr[1:0], 3'b000} +: 8];
   assign lane_h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      be        = '0;
      wdata_rep = wdata;
      rdata     = '0;
      exc       = 1'b0;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << addr[1:0];
            wdata_rep = {4{wdata[7:0]}};
            rdata     = {{24{sign & lane_b[7]}}, lane_b};
         end
         SZ_HALF: begin
            be        = 4'b0011 << addr[1:0];
            wdata_rep = {2{wdata[15:0]}};
            rdata     = {{16{sign & lane_h[15]}}, lane_h};
            exc       = addr[0];
         end
         SZ_WORD: begin
            be    = 4'b1111;
            rdata = mem_rdata;
            exc   = (addr[1:0] != 2'b00);
         end
         default: exc = 1'b1;
      endcase
      if ({1'b0, addr} >= LIMIT) begin
         exc = 1'b1;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// CPU/DMA arbiter for a single-port data memory. Define DM_ARB_ANTISTARVE_EN
// to let DMA win one conflict after STARVE_MAX consecutive CPU-won conflicts.
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int DM_WORDS   = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_sign,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic [31:0] cpu_rdata,
   output logic        cpu_exc,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   logic            force_dma;
   logic [BE_W-1:0] al_be;
   logic [31:0]     al_wdata;
   logic [31:0]     al_rdata;
   logic            al_exc;
   logic [29:0]     dma_word;
   logic            rvalid_q;
   logic [31:0]     rdata_q;
   logic            unused_bits;

   assign unused_bits = ^{dma_addr[1:0], (STARVE_MAX == 0)};

`ifdef DM_ARB_ANTISTARVE_EN
   localparam int CW = $clog2(STARVE_MAX + 1);

   arb_state_t    state, state_nxt;
   logic [CW-1:0] starve_cnt, starve_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CPU_PRI;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // The counter only survives cycles where both sides keep asking in CPU_PRI.
   always_comb begin
      state_nxt  = state;
      starve_nxt = '0;
      case (state)
         CPU_PRI: begin
            if (cpu_req && dma_req) begin
               starve_nxt = starve_cnt + CW'(1);
               if (starve_cnt == CW'(STARVE_MAX - 1)) begin
                  state_nxt = DMA_FORCE;
               end
            end
         end
         DMA_FORCE: state_nxt = CPU_PRI;
         default:   state_nxt = CPU_PRI;
      endcase
   end

   assign force_dma = (state == DMA_FORCE);
`else
   assign force_dma = 1'b0;
`endif

   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (!rst) begin
         if (force_dma && dma_req) begin
            dma_gnt = 1'b1;
         end else if (cpu_req) begin
            cpu_gnt = 1'b1;
         end else if (dma_req) begin
            dma_gnt = 1'b1;
         end
      end
   end

   dm_lane_align #(
      .DM_WORDS (DM_WORDS)
   ) u_align (
      .size      (cpu_size),
      .sign      (cpu_sign),
      .addr      (cpu_addr),
      .wdata     (cpu_wdata),
      .mem_rdata (mem_rdata),
      .be        (al_be),
      .wdata_rep (al_wdata),
      .rdata     (al_rdata),
      .exc       (al_exc)
   );

   // DMA never faults: its word index simply wraps within the memory.
   assign dma_word = dma_addr[31:2] % 30'(DM_WORDS);

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      if (dma_gnt) begin
         mem_we    = dma_we;
         mem_addr  = {dma_word, 2'b00};
         mem_be    = 4'b1111;
         mem_wdata = dma_wdata;
      end else if (cpu_gnt) begin
         mem_we    = cpu_we & ~al_exc;
         mem_addr  = cpu_addr;
         mem_be    = al_be;
         mem_wdata = al_wdata;
      end
   end

   assign cpu_rdata = cpu_gnt ? al_rdata : '0;
   assign cpu_exc   = cpu_gnt & al_exc;

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= dma_gnt & ~dma_we;
         if (dma_gnt && !dma_we) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   // A read granted just before reset must not report valid during the reset cycle.
   assign dma_rvalid = rvalid_q & ~rst;
   assign dma_rdata  = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed scoreboard bench for dm_arbiter with a byte-enabled memory model;
// expectations follow DM_ARB_ANTISTARVE_EN when it is defined.
module tb_dm_arbiter;
   import dm_arbiter_pkg::*;

   logic        clk, rst;
   logic        cpu_req, cpu_we, cpu_sign;
   logic [1:0]  cpu_size;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_gnt, cpu_exc;
   logic [31:0] cpu_rdata;
   logic        dma_req, dma_we, dma_gnt, dma_rvalid;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   logic [31:0] mem [0:4095];

   localparam int S_CGNT = 0, S_DGNT = 1, S_CRD = 2, S_CEXC = 3, S_MWE = 4,
                  S_MBE = 5, S_MWD = 6, S_RVAL = 7, S_DRD = 8, S_MADDR = 9;

   typedef struct {
      string       tag;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;

   dm_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_size   (cpu_size),
      .cpu_sign   (cpu_sign),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rdata  (cpu_rdata),
      .cpu_exc    (cpu_exc),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign mem_rdata = mem[mem_addr[13:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) mem[mem_addr[13:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   function automatic logic [31:0] observe(int sig);
      case (sig)
         S_CGNT:  return {31'b0, cpu_gnt};
         S_DGNT:  return {31'b0, dma_gnt};
         S_CRD:   return cpu_rdata;
         S_CEXC:  return {31'b0, cpu_exc};
         S_MWE:   return {31'b0, mem_we};
         S_MBE:   return {28'b0, mem_be};
         S_MWD:   return mem_wdata;
         S_RVAL:  return {31'b0, dma_rvalid};
         S_DRD:   return dma_rdata;
         S_MADDR: return mem_addr;
         default: return '0;
      endcase
   endfunction

   // Reference load extraction, written lane by lane.
   function automatic logic [31:0] loadModel(logic [31:0] d, logic [1:0] off,
                                             logic [1:0] sz, logic sg);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = off[1] ? d[31:16] : d[15:0];
      if (sz == SZ_BYTE) return (sg && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
      return (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
   endfunction

   task automatic pushExp(string tag, int sig, logic [31:0] val);
      sb.push_back('{tag, sig, val});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic creq, input logic cwe, input logic [1:0] csz,
                                input logic csg, input logic [31:0] caddr,
                                input logic [31:0] cwd, input logic dreq, input logic dwe,
                                input logic [31:0] daddr, input logic [31:0] dwd);
      cpu_req   = creq;
      cpu_we    = cwe;
      cpu_size  = csz;
      cpu_sign  = csg;
      cpu_addr  = caddr;
      cpu_wdata = cwd;
      dma_req   = dreq;
      dma_we    = dwe;
      dma_addr  = daddr;
      dma_wdata = dwd;
   endtask

   task automatic cpuOp(input logic cwe, input logic [1:0] csz, input logic csg,
                        input logic [31:0] caddr, input logic [31:0] cwd);
      applyStimulus(1'b1, cwe, csz, csg, caddr, cwd, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic dmaOp(input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd);
      applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, '0, '0, 1'b1, dwe, daddr, dwd);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic conflict();
      applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, '0, 1'b1, 1'b0, 32'h20, '0);
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [31:0] obs;
      @(negedge clk);
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sig);
         checks++;
         assert (obs === e.val) passes++;
         else begin
            fails++;
            $error("[TB] FAIL %s: observed %h, expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   logic        dma_turn;
   logic [31:0] rd;
   logic [1:0]  roff, rsz;
   logic        rsg;

   initial begin
      // Reset with both sides requesting: nothing may be granted.
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'h1, 1'b1, 1'b1, 32'h20, 32'h2);
      step();
      pushExp("rst_cgnt", S_CGNT, 0);
      pushExp("rst_dgnt", S_DGNT, 0);
      pushExp("rst_mwe", S_MWE, 0);
      pushExp("rst_rvalid", S_RVAL, 0);
      pushExp("rst_drdata", S_DRD, 0);
      checkOutput();
      step();
      rst = 1'b0;

      dmaOp(1'b1, 32'h100, 32'h8001_1234);
      pushExp("dwr_dgnt", S_DGNT, 1);
      pushExp("dwr_cgnt", S_CGNT, 0);
      pushExp("dwr_mwe", S_MWE, 1);
      pushExp("dwr_mbe", S_MBE, 4'hF);
      checkOutput();
      step();
      dmaOp(1'b1, 32'h20, 32'hDEAD_BEEF);
      pushExp("dwr_maddr", S_MADDR, 32'h20);
      checkOutput();

      step(); cpuOp(1'b0, SZ_HALF, 1'b1, 32'h102, '0);
      pushExp("lh_gnt", S_CGNT, 1);
      pushExp("lh", S_CRD, 32'hFFFF_8001);
      pushExp("lh_mwe", S_MWE, 0);
      pushExp("lh_exc", S_CEXC, 0);
      checkOutput();
      step(); cpuOp(1'b0, SZ_HALF, 1'b0, 32'h102, '0);
      pushExp("lhu", S_CRD, 32'h0000_8001);
      checkOutput();
      step(); cpuOp(1'b0, SZ_BYTE, 1'b1, 32'h103, '0);
      pushExp("lb_neg", S_CRD, 32'hFFFF_FF80);
      checkOutput();
      step(); cpuOp(1'b0, SZ_BYTE, 1'b0, 32'h101, '0);
      pushExp("lbu", S_CRD, 32'h0000_0012);
      checkOutput();
      step(); cpuOp(1'b0, SZ_WORD, 1'b0, 32'h100, '0);
      pushExp("lw", S_CRD, 32'h8001_1234);
      checkOutput();

      step(); cpuOp(1'b1, SZ_BYTE, 1'b0, 32'h103, 32'h5A);
      pushExp("sb_gnt", S_CGNT, 1);
      pushExp("sb_be", S_MBE, 4'b1000);
      pushExp("sb_wd", S_MWD, 32'h5A5A_5A5A);
      pushExp("sb_mwe", S_MWE, 1);
      pushExp("sb_exc", S_CEXC, 0);
      checkOutput();
      step(); cpuOp(1'b0, SZ_WORD, 1'b0, 32'h100, '0);
      pushExp("lw_after_sb", S_CRD, 32'h5A01_1234);
      checkOutput();
      step(); cpuOp(1'b1, SZ_HALF, 1'b0, 32'h102, 32'h1234_BEEF);
      pushExp("sh_be", S_MBE, 4'b1100);
      pushExp("sh_wd", S_MWD, 32'hBEEF_BEEF);
      checkOutput();

      // Exception cases: granted, flagged, and never written.
      step(); cpuOp(1'b1, SZ_WORD, 1'b0, 32'h106, 32'hFFFF_FFFF);
      pushExp("sw_mis_exc", S_CEXC, 1);
      pushExp("sw_mis_mwe", S_MWE, 0);
      pushExp("sw_mis_gnt", S_CGNT, 1);
      checkOutput();
      step(); cpuOp(1'b1, SZ_WORD, 1'b0, 32'h102, 32'h0);
      pushExp("sw_mis2_mwe", S_MWE, 0);
      checkOutput();
      step(); cpuOp(1'b0, SZ_WORD, 1'b0, 32'h100, '0);
      pushExp("lw_after_sh", S_CRD, 32'hBEEF_1234);
      checkOutput();
      step(); cpuOp(1'b0, SZ_WORD, 1'b0, 32'h4000, '0);
      pushExp("lw_oor_exc", S_CEXC, 1);
      checkOutput();
      step(); cpuOp(1'b0, SZ_WORD, 1'b0, 32'h3FFC, '0);
      pushExp("lw_top_exc", S_CEXC, 0);
      checkOutput();
      step(); cpuOp(1'b0, SZ_HALF, 1'b0, 32'h101, '0);
      pushExp("lh_mis_exc", S_CEXC, 1);
      checkOutput();
      step(); cpuOp(1'b0, 2'b11, 1'b0, 32'h100, '0);
      pushExp("sz11_exc", S_CEXC, 1);
      checkOutput();

      step();
      applyStimulus(1'b0, 1'b0, SZ_HALF, 1'b1, 32'h101, '0, 1'b0, 1'b0, '0, '0);
      pushExp("noreq_cgnt", S_CGNT, 0);
      pushExp("noreq_exc", S_CEXC, 0);
      pushExp("noreq_rd", S_CRD, 0);
      pushExp("noreq_mbe", S_MBE, 0);
      pushExp("noreq_mwe", S_MWE, 0);
      checkOutput();

      step(); dmaOp(1'b0, 32'h20, '0);
      pushExp("drd_gnt", S_DGNT, 1);
      pushExp("drd_cgnt", S_CGNT, 0);
      pushExp("drd_mbe", S_MBE, 4'hF);
      pushExp("drd_mwe", S_MWE, 0);
      checkOutput();
      step(); idle();
      pushExp("drd_rvalid", S_RVAL, 1);
      pushExp("drd_data", S_DRD, 32'hDEAD_BEEF);
      checkOutput();
      step(); idle();
      pushExp("drd_rvalid_off", S_RVAL, 0);
      checkOutput();

      step(); dmaOp(1'b1, 32'h4024, 32'h1122_3344);
      pushExp("dwrap_maddr", S_MADDR, 32'h24);
      pushExp("dwrap_mwe", S_MWE, 1);
      checkOutput();
      step(); dmaOp(1'b0, 32'h24, '0);
      checkOutput();
      step(); idle();
      pushExp("dwrap_data", S_DRD, 32'h1122_3344);
      checkOutput();

      for (int i = 0; i < 6; i++) begin
         rd   = $urandom;
         rsz  = ($urandom_range(0, 1) == 0) ? SZ_BYTE : SZ_HALF;
         roff = 2'($urandom_range(0, 3));
         if (rsz == SZ_HALF) roff[0] = 1'b0;
         rsg  = 1'($urandom_range(0, 1));
         step(); dmaOp(1'b1, 32'h104, rd);
         checkOutput();
         step(); cpuOp(1'b0, rsz, rsg, {30'h41, roff}, '0);
         pushExp("rand_load", S_CRD, loadModel(rd, roff, rsz, rsg));
         checkOutput();
      end

      // Sustained conflict: with anti-starvation DMA takes the 5th cycle.
      for (int k = 1; k <= 6; k++) begin
`ifdef DM_ARB_ANTISTARVE_EN
         dma_turn = (k == 5);
`else
         dma_turn = 1'b0;
`endif
         step(); conflict();
         pushExp("starve_cgnt", S_CGNT, {31'b0, ~dma_turn});
         pushExp("starve_dgnt", S_DGNT, {31'b0, dma_turn});
         if (k == 6) pushExp("starve_rvalid", S_RVAL, {31'b0, ~cpu_gnt & 1'b0} | {31'b0,
`ifdef DM_ARB_ANTISTARVE_EN
            1'b1
`else
            1'b0
`endif
         });
         checkOutput();
      end
      step(); idle();
      checkOutput();

      // DMA read granted, then reset on the next cycle.
      step(); dmaOp(1'b0, 32'h20, '0);
      pushExp("pre_rst_dgnt", S_DGNT, 1);
      checkOutput();
      step(); rst = 1'b1; conflict();
      pushExp("rst2_rvalid", S_RVAL, 0);
      pushExp("rst2_cgnt", S_CGNT, 0);
      pushExp("rst2_dgnt", S_DGNT, 0);
      checkOutput();
      step(); rst = 1'b0; idle();
      pushExp("post_rst_rvalid", S_RVAL, 0);
      pushExp("post_rst_drdata", S_DRD, 0);
      checkOutput();

      // Partially built-up starvation must be forgotten across reset.
      for (int k = 1; k <= 3; k++) begin
         step(); conflict();
         checkOutput();
      end
      step(); rst = 1'b1; conflict();
      checkOutput();
      step(); rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
`ifdef DM_ARB_ANTISTARVE_EN
         dma_turn = (k == 5);
`else
         dma_turn = 1'b0;
`endif
         if (k > 1) step();
         conflict();
         pushExp("rst_cnt_cgnt", S_CGNT, {31'b0, ~dma_turn});
         pushExp("rst_cnt_dgnt", S_DGNT, {31'b0, dma_turn});
         checkOutput();
      end
      step(); idle();
      checkOutput();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive CPU-won conflict cycles before DMA is forced.
REQ-002 SHALL have parameter DM_WORDS, default 4096: data memory depth in words; valid byte range is 0 to 4*DM_WORDS-1.
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have CPU ports: cpu_req in 1; cpu_we in 1; cpu_size in 2 (00 byte, 01 half, 10 word); cpu_sign in 1 (load sign-extend); cpu_addr in 32; cpu_wdata in 32.
REQ-006 SHALL have CPU outputs: cpu_gnt out 1 (access done this cycle, else stall); cpu_rdata out 32 (aligned, extended load data); cpu_exc out 1 (misaligned or out-of-range).
REQ-007 SHALL have DMA ports: dma_req in 1; dma_we in 1; dma_addr in 32 (word access only); dma_wdata in 32; dma_gnt out 1; dma_rvalid out 1; dma_rdata out 32.
REQ-008 SHALL have memory ports: mem_we out 1; mem_addr out 32; mem_be out 4; mem_wdata out 32; mem_rdata in 32 (combinational read of word mem_addr[31:2]).

Function
REQ-009 SHALL grant at most one requester per cycle; grants combinational from req, state and counter.
REQ-010 SHALL use FSM states CPU_PRI (CPU wins conflicts) and DMA_FORCE (DMA wins next conflict).
REQ-011 In CPU_PRI, cpu_req=1 SHALL grant CPU; DMA granted only when cpu_req=0.
REQ-012 Each CPU_PRI cycle with cpu_req=1 and dma_req=1 SHALL increment starve_cnt; starve_cnt==STARVE_MAX-1 on such a cycle SHALL move to DMA_FORCE.
REQ-013 In DMA_FORCE, dma_req=1 SHALL grant DMA (cpu_gnt=0), clear starve_cnt, return to CPU_PRI; dma_req=0 SHALL grant CPU per REQ-011, clear starve_cnt, return to CPU_PRI.
REQ-014 Any cycle with dma_req=0 or cpu_req=0 SHALL clear starve_cnt.
REQ-015 CPU be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; DMA be always 4'b1111.
REQ-016 Store data SHALL be lane-replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-017 cpu_rdata SHALL extract the selected lane of mem_rdata, sign- or zero-extended per cpu_sign; word returned unchanged.
REQ-018 CPU misalignment (half with addr[0]=1, word with addr[1:0]!=0), size 11, or addr >= 4*DM_WORDS SHALL assert cpu_exc in the grant cycle and force mem_we=0; cpu_gnt still 1.
REQ-019 DMA addresses SHALL be masked to word index modulo DM_WORDS (wrap-around, no exception).
REQ-020 DMA read data SHALL be registered: dma_rvalid=1 and dma_rdata=read word exactly one cycle after the granting cycle.
REQ-021 mem_we SHALL equal granted requester's we (after REQ-018 masking); with no grant mem_we=0, mem_be=0.
REQ-022 cpu_rdata, cpu_exc SHALL be 0 when cpu_gnt=0.

Reset
REQ-023 rst SHALL set state CPU_PRI, starve_cnt 0, dma_rvalid 0, dma_rdata 0; during rst cycle all grants and mem_we SHALL be 0.
REQ-024 A DMA read granted in the cycle before rst SHALL NOT produce dma_rvalid.

Configuration
REQ-025 Macro DM_ARB_ANTISTARVE_EN defined: REQ-010..REQ-014 active.
REQ-026 DM_ARB_ANTISTARVE_EN undefined: strict CPU priority, no counter, FSM fixed at CPU_PRI.

Structure
REQ-027 Shared package SHALL hold size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state typedef, be width constant.
REQ-028 Sub-module dm_lane_align SHALL hold REQ-015..REQ-018 (be, store replicate, load extract, exception detect) combinationally.

Verification
REQ-029 CPU sb addr 0x103, wdata 0x5A -> mem_be 4'b1000, mem_wdata 0x5A5A5A5A, cpu_gnt 1.
REQ-030 CPU lh sign addr 0x102, mem_rdata 0x8001_1234 -> cpu_rdata 0xFFFF8001; lhu -> 0x00008001.
REQ-031 CPU sw addr 0x106 -> cpu_exc 1, mem_we 0; lw addr 0x4000 -> cpu_exc 1.
REQ-032 cpu_req, dma_req both held 1, STARVE_MAX=4, macro on -> CPU granted 4 cycles, DMA 5th, CPU 6th; macro off -> DMA never granted.
REQ-033 DMA read addr 0x20 with cpu_req=0, mem word 0xDEADBEEF -> dma_gnt 1, next cycle dma_rvalid 1, dma_rdata 0xDEADBEEF.
REQ-034 DMA read granted, rst next cycle -> dma_rvalid 0, state CPU_PRI, starve_cnt 0.
